// File: rtl/lu_pkg.sv
// lu_pkg: shared constants, state encoding and emit-time helper for the LU feeder.
package lu_pkg;
  localparam int N          = 4;
  localparam int NLANES     = 7;
  localparam int STREAM_LEN = 10;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;
  function automatic logic [3:0] emit_time(input logic [1:0] i, input logic [1:0] j);
    return 4'(i) + 4'(j) + 4'((i > j) ? i : j);
  endfunction
endpackage

// File: rtl/lu_skew_feeder_if.sv
// lu_skew_feeder_if: host write port, start/status handshake and the seven diagonal lanes.
interface lu_skew_feeder_if #(parameter int iSZ = 8);
  logic           wr_en;
  logic [1:0]     wr_row;
  logic [1:0]     wr_col;
  logic [iSZ-1:0] wr_data;
  logic           start;
  logic           busy;
  logic           active;
  logic           done;
  logic [iSZ-1:0] oL1, oL2, oL3, oL4, oL5, oL6, oL7;
  modport master (
    output wr_en, wr_row, wr_col, wr_data, start,
    input  busy, active, done, oL1, oL2, oL3, oL4, oL5, oL6, oL7
  );
  modport slave (
    input  wr_en, wr_row, wr_col, wr_data, start,
    output busy, active, done, oL1, oL2, oL3, oL4, oL5, oL6, oL7
  );
endinterface

// File: rtl/lu_matrix_store.sv
// lu_matrix_store: 4x4 element register file with one write port and full parallel read.
module lu_matrix_store
  import lu_pkg::*;
#(
  parameter int iSZ = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we_i,
  input  logic [1:0]     row_i,
  input  logic [1:0]     col_i,
  input  logic [iSZ-1:0] data_i,
  output logic [iSZ-1:0] mat_o [N][N]
);
  logic [iSZ-1:0] mem_q [N][N];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else if (we_i) mem_q[row_i][col_i] <= data_i;
  end
  assign mat_o = mem_q;
endmodule

// File: rtl/lu_skew_feeder.sv
// lu_skew_feeder: streams a stored 4x4 matrix onto seven skewed diagonal lanes, drains, then pulses done.
module lu_skew_feeder
  import lu_pkg::*;
#(
  parameter int iSZ       = 8,
  parameter int DRAIN_CYC = 12
) (
  input  logic            clk,
  input  logic            rst,
  lu_skew_feeder_if.slave bus
);
  localparam int CW = $clog2(DRAIN_CYC > STREAM_LEN ? DRAIN_CYC : STREAM_LEN);
  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [iSZ-1:0] lanes_q [NLANES];
  logic           active_q, busy_q, done_q;
  logic           idle_wr;
  logic [iSZ-1:0] mat [N][N];
  logic [iSZ-1:0] eff [N][N];
  logic [iSZ-1:0] lane_d [NLANES];
  logic [3:0]     t_nxt;
  assign idle_wr = bus.wr_en && state_q == IDLE;
  lu_matrix_store #(.iSZ(iSZ)) u_store (
    .clk   (clk),
    .rst   (rst),
    .we_i  (idle_wr),
    .row_i (bus.wr_row),
    .col_i (bus.wr_col),
    .data_i(bus.wr_data),
    .mat_o (mat)
  );
  // Forward a same-cycle write so a start in that cycle streams the new value.
  always_comb begin
    eff = mat;
    if (idle_wr) eff[bus.wr_row][bus.wr_col] = bus.wr_data;
    t_nxt = state_q == IDLE ? 4'd0 : 4'(cnt_q + 1'b1);
    lane_d = '{default: '0};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (emit_time(2'(i), 2'(j)) == t_nxt) lane_d[j - i + 3] = eff[i][j];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lanes_q  <= '{default: '0};
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_q  <= STREAM;
          cnt_q    <= '0;
          lanes_q  <= lane_d;
          active_q <= 1'b1;
          busy_q   <= 1'b1;
        end
        STREAM: if (cnt_q == CW'(STREAM_LEN - 1)) begin
          state_q  <= DRAIN;
          cnt_q    <= '0;
          lanes_q  <= '{default: '0};
          active_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_q + 1'b1;
          lanes_q <= lane_d;
        end
        DRAIN: if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_q <= DONE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.oL1    = lanes_q[0];
  assign bus.oL2    = lanes_q[1];
  assign bus.oL3    = lanes_q[2];
  assign bus.oL4    = lanes_q[3];
  assign bus.oL5    = lanes_q[4];
  assign bus.oL6    = lanes_q[5];
  assign bus.oL7    = lanes_q[6];
  assign bus.active = active_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_lu_skew_feeder.sv
// tb_lu_skew_feeder: directed scoreboard bench for the skewed LU matrix feeder.
module tb_lu_skew_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  lu_skew_feeder_if #(.iSZ(8)) bus ();
  lu_skew_feeder #(.iSZ(8), .DRAIN_CYC(12)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [55:0] lanes;
    logic        active;
    logic        busy;
    logic        done;
  } exp_t;
  exp_t        sb[$];
  logic [7:0]  m [4][4];
  logic [55:0] lanes_w;
  int          checks = 0;
  int          errors = 0;
  logic        seen_done;
  assign lanes_w = {bus.oL7, bus.oL6, bus.oL5, bus.oL4, bus.oL3, bus.oL2, bus.oL1};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, " lanes"}, 64'(lanes_w), 64'd0);
    chk({tag, " active"}, 64'(bus.active), 64'd0);
    chk({tag, " busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " done"}, 64'(bus.done), 64'd0);
  endtask
  task automatic push_run();
    logic [55:0] v [10];
    int t;
    for (int k = 0; k < 10; k++) v[k] = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        t = i + j + ((i > j) ? i : j);
        v[t][(j - i + 3) * 8 +: 8] = m[i][j];
      end
    for (int k = 0; k < 10; k++) sb.push_back('{v[k], 1'b1, 1'b1, 1'b0});
    for (int k = 0; k < 12; k++) sb.push_back('{56'd0, 1'b0, 1'b1, 1'b0});
    sb.push_back('{56'd0, 1'b0, 1'b0, 1'b1});
  endtask
  task automatic run(input int wr_k, input int st_k);
    exp_t e;
    push_run();
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("lanes k=%0d", k), 64'(lanes_w), 64'(e.lanes));
      chk($sformatf("active k=%0d", k), 64'(bus.active), 64'(e.active));
      chk($sformatf("busy k=%0d", k), 64'(bus.busy), 64'(e.busy));
      chk($sformatf("done k=%0d", k), 64'(bus.done), 64'(e.done));
      bus.wr_en = (k == wr_k);
      bus.start = (k == st_k);
    end
  endtask
  task automatic wr(input int i, input int j, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_row  = 2'(i);
    bus.wr_col  = 2'(j);
    bus.wr_data = d;
    m[i][j]     = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask
  initial begin
    bus.wr_en = 0; bus.wr_row = 0; bus.wr_col = 0; bus.wr_data = 0; bus.start = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = '0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("in_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after_reset");
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) wr(i, j, 8'(16 * i + j + 1));
    bus.start = 1'b1;
    run(0, 0);
    @(negedge clk);
    chk_idle_outputs("post_run1");
    bus.wr_row = 2'd1; bus.wr_col = 2'd1; bus.wr_data = 8'hAA;
    bus.start = 1'b1;
    run(3, 5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("no_restart busy %0d", k), 64'(bus.busy), 64'd0);
      chk($sformatf("no_restart done %0d", k), 64'(bus.done), 64'd0);
    end
    bus.start = 1'b1;
    run(0, 0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst active", 64'(bus.active), 64'd1);
    #2 rst = 1'b1;
    #1 chk_idle_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = '0;
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      seen_done |= bus.done;
    end
    chk("no_done_after_rst", 64'(seen_done), 64'd0);
    bus.start = 1'b1;
    run(0, 0);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_row = 2'd0; bus.wr_col = 2'd0; bus.wr_data = 8'h7F;
    m[0][0] = 8'h7F;
    bus.start = 1'b1;
    run(0, 0);
    @(negedge clk);
    chk("b2b gap busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b1;
    run(0, 0);
    @(negedge clk);
    bus.start = 1'b1;
    run(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
